cpu_exec_unit: RTL and testbench
================================

# cpu_exec_unit

Execution stage directly downstream of the instruction ROM. Each ROM entry supplies a 9-bit instruction and a 16-bit data word. This block executes that pair against an internal 8×16-bit register file, then pulses `step` to advance the ROM to the next entry. It stops permanently on the terminate opcode and exposes its register file through a debug read port.

## Interface
Parameters:
- `NREGS`, default 8: register count; fixed at 8 because the register fields are 3 bits wide.
- `DW`, default 16: data and register width; must equal the ROM data width.

Ports:
- `clk` input, 1: system clock; all state changes on its rising edge.
- `reset_n` input, 1: asynchronous, active-low reset.
- `instruction` input, 9: from the ROM. Fields: [8:6] opcode, [5:3] rx (destination), [2:0] ry (source).
- `data_var` input, 16: ROM immediate; used only by load.
- `step` output, 1: registered; a one-cycle high pulse requests the next ROM entry.
- `halted` output, 1: registered; high once terminate has executed.
- `retired` output, 8: count of executed instructions, including terminate.
- `dbg_sel` input, 3: register index for debug read.
- `dbg_data` output, 16: combinational read of register `dbg_sel`.
- `flag_z` output, 1: zero flag (see Configuration).
- `flag_c` output, 1: carry flag (see Configuration).

## Operation
- Opcodes:
  - 000 load: rx ← data_var.
  - 001 move: rx ← ry.
  - 010 add: rx ← rx + ry, modulo 2^16.
  - 011 xor: rx ← rx ^ ry.
  - 100 terminate.
  - 101–111: NOP. The instruction advances and retires, and no register changes.
- Operands are read before the write, so rx = ry is legal. Example: add r3,r3 doubles r3.
- FSM states:
  - WAIT: one settle cycle for the ROM output; then → EXEC.
  - EXEC: execute the current instruction and increment `retired`. Terminate → HALT; all other opcodes → STEP.
  - STEP: `step`=1 for exactly this cycle; then → WAIT.
  - HALT: absorbing state; `halted`=1 and `step`=0. Only reset leaves it.
- `instruction` and `data_var` are sampled only in EXEC. Changes in other states are ignored.
- `retired` wraps from 255 to 0 without side effects.
- `dbg_data` reflects a write on the cycle after the EXEC edge.

## Timing
- Reset values:
  - state = WAIT.
  - All registers = 0.
  - `step`=0, `halted`=0, `retired`=0, `flag_z`=0, `flag_c`=0.
- One instruction takes 3 cycles: EXEC, STEP, WAIT.
- After `reset_n` deasserts, the first rising edge is in WAIT. Instruction k (k = 0, 1, …) executes on edge 2+3k.
- `step` rises on the edge after EXEC and falls one edge later. The ROM's next output is valid before the following EXEC edge.
- `halted` rises on the edge after the terminate EXEC and holds.
- Reset mid-operation clears all state immediately, including a `step` pulse in progress.
- Reset does not rewind the ROM address. The system-level restart is responsible for re-initialising the ROM.

## Configuration
- With `CPU_EXEC_FLAGS_EN` defined, add and xor update the flags in EXEC:
  - `flag_z` = (result == 0).
  - `flag_c` = carry out of bit 15 on add; 0 on xor.
  - load, move, NOP and terminate leave both flags unchanged.
- Without `CPU_EXEC_FLAGS_EN`, no flag registers exist and `flag_z` and `flag_c` are tied to 0.

## Test plan
- Program with the ROM model: load r0,5; load r1,4; add r1,r0; move r6,r0; xor r6,r1; terminate.
  - Required: r0=5, r1=9, r6=12 (0x000C), all other registers 0.
  - Required: exactly 5 `step` pulses, `halted` high from edge 18, `retired`=6.
- Step protocol: from reset, `step` is high only on edges 3, 6, 9, …, each pulse one cycle wide. Changing `instruction` outside EXEC has no effect.
- Add overflow:
  - Sequence: load r2,0xFFFF; load r3,1; add r2,r3.
  - Required: r2=0. With the flags macro defined, `flag_z`=1 and `flag_c`=1; without it, both flags stay 0.
- Same-register and NOP:
  - add r4,r4 with r4=0x4000 gives r4=0x8000.
  - Opcode 110 retires (`retired` increments), changes no register and is followed by a `step` pulse.
- Async reset: assert `reset_n`=0 during a STEP cycle. `step` drops without a clock edge, and all registers, `retired` and `halted` read 0. Execution resumes in WAIT.
- Halt stickiness: after terminate, hold the clock for 50 cycles. Required: `step`=0 throughout, `halted`=1, and `retired` unchanged.

Source files
------------

// File: rtl/cpu_exec_unit.sv
// Executes one ROM instruction/data pair per 3-cycle WAIT/EXEC/STEP round against an 8x16 register file.
// step is a one-cycle request for the next ROM entry, with no stall input; CPU_EXEC_FLAGS_EN adds zero/carry flags.
module cpu_exec_unit #(
  parameter int NREGS = 8,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [8:0]    instruction,
  input  logic [DW-1:0] data_var,
  output logic          step,
  output logic          halted,
  output logic [7:0]    retired,
  input  logic [2:0]    dbg_sel,
  output logic [DW-1:0] dbg_data,
  output logic          flag_z,
  output logic          flag_c
);

  typedef enum logic [1:0] {S_WAIT, S_EXEC, S_STEP, S_HALT} state_t;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_MOVE = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_TERM = 3'd4;

  state_t        state_q, state_d;
  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];
  logic [7:0]    retired_q, retired_d;
  logic          step_q, step_d;
  logic          halted_q, halted_d;

  logic [2:0]    op, rx, ry;
  logic [DW-1:0] src_x, src_y, xor_res;
  logic [DW:0]   sum;

  assign op      = instruction[8:6];
  assign rx      = instruction[5:3];
  assign ry      = instruction[2:0];
  // Both operands come from the pre-write register file, so rx == ry is safe.
  assign src_x   = regs_q[rx];
  assign src_y   = regs_q[ry];
  assign sum     = {1'b0, src_x} + {1'b0, src_y};
  assign xor_res = src_x ^ src_y;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  state_d = S_EXEC;
      S_EXEC:  state_d = (op == OP_TERM) ? S_HALT : S_STEP;
      S_STEP:  state_d = S_WAIT;
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    step_d   = (state_q == S_STEP);
    halted_d = (state_q == S_HALT);
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    retired_d = retired_q;
    if (state_q == S_EXEC) begin
      retired_d = retired_q + 8'd1;
      case (op)
        OP_LOAD: regs_d[rx] = data_var;
        OP_MOVE: regs_d[rx] = src_y;
        OP_ADD:  regs_d[rx] = sum[DW-1:0];
        OP_XOR:  regs_d[rx] = xor_res;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      retired_q <= '0;
      step_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      retired_q <= retired_d;
      step_q    <= step_d;
      halted_q  <= halted_d;
    end
  end

`ifdef CPU_EXEC_FLAGS_EN
  logic flag_z_q, flag_z_d, flag_c_q, flag_c_d;

  always_comb begin
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    if (state_q == S_EXEC) begin
      if (op == OP_ADD) begin
        flag_z_d = (sum[DW-1:0] == '0);
        flag_c_d = sum[DW];
      end else if (op == OP_XOR) begin
        flag_z_d = (xor_res == '0);
        flag_c_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
`else
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
`endif

  assign step     = step_q;
  assign halted   = halted_q;
  assign retired  = retired_q;
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Randomized bench for cpu_exec_unit: ROM model driven by step, program-level reference model checked every cycle.
module tb_cpu_exec_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [8:0]  instruction;
  logic [15:0] data_var;
  logic        step, halted;
  logic [7:0]  retired;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data;
  logic        flag_z, flag_c;

  cpu_exec_unit #(.NREGS(8), .DW(16)) dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .data_var(data_var),
    .step(step), .halted(halted), .retired(retired), .dbg_sel(dbg_sel),
    .dbg_data(dbg_data), .flag_z(flag_z), .flag_c(flag_c)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Program memory shared by the ROM model and the reference model.
  logic [8:0]  p_ins [64];
  logic [15:0] p_dat [64];

  int rom_addr;
  int ecnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr <= 0;
      ecnt     <= 0;
    end else begin
      ecnt <= ecnt + 1;
      if (step) rom_addr <= rom_addr + 1;
    end
  end

  // Reference model: architectural state after each executed instruction.
  logic [15:0] m_r [8];
  logic [7:0]  m_ret;
  logic        m_z, m_c, m_done;
  int          m_k, halt_edge, steps_seen, first_halt, n;
  logic        e_step, e_halt;
  bit          mon_en = 1'b1;
  bit          garbage = 1'b0;

  task automatic model_exec(input logic [8:0] ins, input logic [15:0] d, input int edge_n);
    logic [2:0]  op, x, y;
    logic [16:0] s;
    op = ins[8:6]; x = ins[5:3]; y = ins[2:0];
    m_ret = m_ret + 8'd1;
    case (op)
      3'd0: m_r[x] = d;
      3'd1: m_r[x] = m_r[y];
      3'd2: begin
        s = m_r[x] + m_r[y];
        m_r[x] = s[15:0];
`ifdef CPU_EXEC_FLAGS_EN
        m_z = (s[15:0] == 16'd0);
        m_c = s[16];
`endif
      end
      3'd3: begin
        m_r[x] = m_r[x] ^ m_r[y];
`ifdef CPU_EXEC_FLAGS_EN
        m_z = (m_r[x] == 16'd0);
        m_c = 1'b0;
`endif
      end
      3'd4: begin
        m_done = 1'b1;
        halt_edge = edge_n + 1;
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) m_r[i] = 16'd0;
      m_ret = 8'd0; m_z = 1'b0; m_c = 1'b0; m_done = 1'b0;
      m_k = 0; halt_edge = 1 << 30; steps_seen = 0; first_halt = 0;
    end else begin
      n = ecnt;
      if (n >= 2 && n % 3 == 2 && !m_done) begin
        model_exec(p_ins[m_k], p_dat[m_k], n);
        m_k++;
      end
      e_step = (n >= 3) && (n % 3 == 0) && (n < halt_edge);
      e_halt = (n >= halt_edge);
      if (step === 1'b1) steps_seen++;
      if (halted === 1'b1 && first_halt == 0) first_halt = n;
      if (mon_en) begin
        dbg_sel = 3'($urandom_range(0, 7));
        #1;
        check($sformatf("step@%0d", n), step, e_step);
        check($sformatf("halted@%0d", n), halted, e_halt);
        check($sformatf("retired@%0d", n), retired, m_ret);
        check($sformatf("dbg r%0d@%0d", dbg_sel, n), dbg_data, m_r[dbg_sel]);
        check($sformatf("flag_z@%0d", n), flag_z, m_z);
        check($sformatf("flag_c@%0d", n), flag_c, m_c);
      end
    end
    // Only EXEC-cycle inputs matter; other cycles may carry junk.
    if (!garbage || ((ecnt + 1) % 3 == 2)) begin
      instruction = p_ins[rom_addr % 64];
      data_var    = p_dat[rom_addr % 64];
    end else begin
      instruction = 9'($urandom);
      data_var    = 16'($urandom);
    end
  end

  function automatic logic [8:0] mk(input int op, input int x, input int y);
    mk = {3'(op), 3'(x), 3'(y)};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) begin
      p_ins[i] = mk(4, 0, 0);
      p_dat[i] = 16'd0;
    end
  endtask

  task automatic load_main();
    clear_prog();
    p_ins[0] = mk(0, 0, 0); p_dat[0] = 16'd5;
    p_ins[1] = mk(0, 1, 0); p_dat[1] = 16'd4;
    p_ins[2] = mk(2, 1, 0);
    p_ins[3] = mk(1, 6, 0);
    p_ins[4] = mk(3, 6, 1);
    p_ins[5] = mk(4, 0, 0);
  endtask

  task automatic check_regs(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4,
                            input logic [15:0] e5, input logic [15:0] e6, input logic [15:0] e7);
    logic [15:0] ev [8];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    ev[4] = e4; ev[5] = e5; ev[6] = e6; ev[7] = e7;
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      check($sformatf("%s r%0d", tag, i), dbg_data, ev[i]);
    end
  endtask

  task automatic reset_and_go();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst step", step, 1'b0);
    check("rst halted", halted, 1'b0);
    check("rst retired", retired, 8'd0);
    check("rst flag_z", flag_z, 1'b0);
    check("rst flag_c", flag_c, 1'b0);
    @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    instruction = 9'd0; data_var = 16'd0; dbg_sel = 3'd0;
    clear_prog();

    // Reference program, then halt stickiness.
    load_main();
    reset_and_go();
    repeat (25) @(posedge clk);
    mon_en = 1'b0;
    check_regs("main", 16'd5, 16'd9, 0, 0, 0, 0, 16'h000C, 0);
    check("main retired", retired, 8'd6);
    check("main halted", halted, 1'b1);
    check("main steps", steps_seen, 5);
    check("main halt edge", first_halt, 18);
    mon_en = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("sticky retired", retired, 8'd6);
    check("sticky steps", steps_seen, 5);
    check("sticky halted", halted, 1'b1);

    // Overflow, same-register add, NOP.
    clear_prog();
    p_ins[0] = mk(0, 2, 0); p_dat[0] = 16'hFFFF;
    p_ins[1] = mk(0, 3, 0); p_dat[1] = 16'd1;
    p_ins[2] = mk(2, 2, 3);
    p_ins[3] = mk(0, 4, 0); p_dat[3] = 16'h4000;
    p_ins[4] = mk(2, 4, 4);
    p_ins[5] = mk(6, 5, 1);
    p_ins[6] = mk(4, 0, 0);
    reset_and_go();
    repeat (9) @(posedge clk);
    #1;
`ifdef CPU_EXEC_FLAGS_EN
    check("ovf flag_z", flag_z, 1'b1);
    check("ovf flag_c", flag_c, 1'b1);
`else
    check("ovf flag_z", flag_z, 1'b0);
    check("ovf flag_c", flag_c, 1'b0);
`endif
    repeat (16) @(posedge clk);
    mon_en = 1'b0;
    check_regs("ovf", 0, 0, 16'h0000, 16'd1, 16'h8000, 0, 0, 0);
    check("ovf retired", retired, 8'd7);
    check("ovf steps", steps_seen, 6);
    mon_en = 1'b1;

    // Random programs with junk on the ROM bus outside EXEC.
    garbage = 1'b1;
    for (int t = 0; t < 3; t++) begin
      clear_prog();
      for (int i = 0; i < 20; i++) begin
        int op;
        op = $urandom_range(0, 6);
        if (op >= 4) op++;
        p_ins[i] = mk(op, $urandom_range(0, 7), $urandom_range(0, 7));
        p_dat[i] = 16'($urandom);
      end
      reset_and_go();
      repeat (3 * 21 + 6) @(posedge clk);
      #1;
      check("rand halted", halted, 1'b1);
      check("rand retired", retired, 8'd21);
    end

    // Asynchronous reset while step is high.
    load_main();
    reset_and_go();
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(posedge clk);
        #2;
        if (step === 1'b1 && ecnt >= 6) seen = 1'b1;
      end
      check("arst step seen", seen, 1'b1);
    end
    reset_n = 1'b0;
    #1;
    check("arst step", step, 1'b0);
    check("arst retired", retired, 8'd0);
    check("arst halted", halted, 1'b0);
    check_regs("arst", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (25) @(posedge clk);
    mon_en = 1'b0;
    check_regs("resume", 16'd5, 16'd9, 0, 0, 0, 0, 16'h000C, 0);
    check("resume retired", retired, 8'd6);
    check("resume halt edge", first_halt, 18);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
